// File: rtl/asip_defs.sv
// Shared definitions for the max/min/avg ASIP: FSM state encodings and
// the default address/count widths.
package asip_defs;

  localparam int ASIP_ADDR_W = 8;
  localparam int ASIP_CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    RESULT = 2'd2,
    FINISH = 2'd3
  } state_e;

endpackage

// File: rtl/addr_seq_unit.sv
// Address sequencer: walks COUNT operands from BASE_ADDR, tracks the address of
// the best element and presents it for one result beat through the address mux.
module addr_seq_unit
  import asip_defs::*;
#(
  parameter int ADDR_W = ASIP_ADDR_W,
  parameter int CNT_W  = ASIP_CNT_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  input  logic [CNT_W-1:0]  COUNT,
  input  logic              ADDR_READY,
  input  logic              CAPTURE,
  output logic [ADDR_W-1:0] ADD_R_out,
  output logic [ADDR_W-1:0] TEMP_ADD_R_out,
  output logic              Select_line,
  output logic              ADDR_VALID,
  output logic              BUSY,
  output logic              DONE
);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addR_q, addR_d;
  logic [ADDR_W-1:0]  tempAddR_q, tempAddR_d;
  logic [CNT_W-1:0]   rem_q, rem_d;

  // State and datapath registers; reset wins over every input.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      addR_q     <= '0;
      tempAddR_q <= '0;
      rem_q      <= '0;
    end else begin
      state_q    <= state_d;
      addR_q     <= addR_d;
      tempAddR_q <= tempAddR_d;
      rem_q      <= rem_d;
    end
  end

  // Next state plus register updates. A beat is accepted only in SCAN or
  // RESULT, where ADDR_VALID is high by construction, so READY alone decides.
  always_comb begin
    state_d    = state_q;
    addR_d     = addR_q;
    tempAddR_d = tempAddR_q;
    rem_d      = rem_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          addR_d     = BASE_ADDR;
          tempAddR_d = BASE_ADDR;
          rem_d      = COUNT;
          state_d    = (COUNT == '0) ? FINISH : SCAN;
        end
      end
      SCAN: begin
        if (ADDR_READY) begin
          addR_d = addR_q + ADDR_W'(1);
          rem_d  = rem_q - CNT_W'(1);
          if (CAPTURE) tempAddR_d = addR_q;
          if (rem_q == CNT_W'(1)) state_d = RESULT;
        end
      end
      RESULT: begin
        if (ADDR_READY) state_d = FINISH;
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake and mux controls decode from state alone.
  always_comb begin
    Select_line = 1'b0;
    ADDR_VALID  = 1'b0;
    BUSY        = 1'b0;
    DONE        = 1'b0;
    case (state_q)
      SCAN: begin
        ADDR_VALID = 1'b1;
        BUSY       = 1'b1;
      end
      RESULT: begin
        Select_line = 1'b1;
        ADDR_VALID  = 1'b1;
        BUSY        = 1'b1;
      end
      FINISH: begin
        DONE = 1'b1;
      end
      default: begin
        DONE = 1'b0;
      end
    endcase
  end

  assign ADD_R_out      = addR_q;
  assign TEMP_ADD_R_out = tempAddR_q;

endmodule

// File: tb/tb_addr_seq_unit.sv
// Self-checking bench for addr_seq_unit: directed scenarios followed by random
// traffic, all compared cycle by cycle against a transaction-level model.
module tb_addr_seq_unit;

  logic       CLK;
  logic       RST;
  logic       START;
  logic [7:0] BASE_ADDR;
  logic [7:0] COUNT;
  logic       ADDR_READY;
  logic       CAPTURE;
  logic [7:0] ADD_R_out;
  logic [7:0] TEMP_ADD_R_out;
  logic       Select_line;
  logic       ADDR_VALID;
  logic       BUSY;
  logic       DONE;

  int compared   = 0;
  int mismatched = 0;
  int doneSeen   = 0;

  // Model: a scan is described by its base, its length, how many scan beats
  // have been accepted, whether the result beat went out, and the best index.
  bit       mdlActive;
  bit       mdlResultShown;
  int       mdlCount;
  int       mdlBeats;
  int       mdlBase;
  int       mdlTemp;

  addr_seq_unit dut (
    .CLK            (CLK),
    .RST            (RST),
    .START          (START),
    .BASE_ADDR      (BASE_ADDR),
    .COUNT          (COUNT),
    .ADDR_READY     (ADDR_READY),
    .CAPTURE        (CAPTURE),
    .ADD_R_out      (ADD_R_out),
    .TEMP_ADD_R_out (TEMP_ADD_R_out),
    .Select_line    (Select_line),
    .ADDR_VALID     (ADDR_VALID),
    .BUSY           (BUSY),
    .DONE           (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed,
               expected, $time);
    end
  endtask

  function automatic bit mdlScanning();
    return mdlActive && (mdlBeats < mdlCount);
  endfunction

  function automatic bit mdlResulting();
    return mdlActive && (mdlCount > 0) && (mdlBeats == mdlCount) && !mdlResultShown;
  endfunction

  function automatic bit mdlFinishing();
    return mdlActive && ((mdlCount == 0) || mdlResultShown);
  endfunction

  // Compare every output against what the model says this cycle should show.
  task automatic checkAll();
    bit expValid;
    expValid = mdlScanning() || mdlResulting();
    checkOutput("ADD_R", ADD_R_out, (mdlBase + mdlBeats) % 256);
    checkOutput("TEMP_ADD_R", TEMP_ADD_R_out, mdlTemp);
    checkOutput("ADDR_VALID", ADDR_VALID, expValid);
    checkOutput("Select_line", Select_line, mdlResulting());
    checkOutput("BUSY", BUSY, expValid);
    checkOutput("DONE", DONE, mdlFinishing());
    if (DONE === 1'b1) doneSeen++;
  endtask

  // Advance the model across one clock edge with the inputs now applied.
  task automatic updateModel();
    if (RST) begin
      mdlActive = 0; mdlResultShown = 0;
      mdlCount = 0; mdlBeats = 0; mdlBase = 0; mdlTemp = 0;
    end else if (!mdlActive) begin
      if (START) begin
        mdlActive = 1; mdlResultShown = 0;
        mdlBase = BASE_ADDR; mdlCount = COUNT; mdlBeats = 0; mdlTemp = BASE_ADDR;
      end
    end else if (mdlScanning()) begin
      if (ADDR_READY) begin
        if (CAPTURE) mdlTemp = (mdlBase + mdlBeats) % 256;
        mdlBeats++;
      end
    end else if (mdlResulting()) begin
      if (ADDR_READY) mdlResultShown = 1;
    end else begin
      mdlActive = 0;
    end
  endtask

  // Drive one cycle of inputs, clock it through, and check at the falling edge.
  task automatic applyStimulus(input logic rst, input logic start,
                               input logic [7:0] base, input logic [7:0] cnt,
                               input logic ready, input logic capture);
    RST = rst; START = start; BASE_ADDR = base; COUNT = cnt;
    ADDR_READY = ready; CAPTURE = capture;
    updateModel();
    @(posedge CLK);
    @(negedge CLK);
    checkAll();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 8'h00, 8'h00, 1, 0);
  endtask

  initial begin
    mdlActive = 0; mdlResultShown = 0;
    mdlCount = 0; mdlBeats = 0; mdlBase = 0; mdlTemp = 0;

    applyStimulus(1, 0, 8'h00, 8'h00, 0, 0);
    applyStimulus(1, 0, 8'h00, 8'h00, 0, 0);
    idleCycles(2);

    $display("[TB] T1 reset mid-scan");
    applyStimulus(0, 1, 8'h10, 8'd4, 1, 0);
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 0);
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 0);
    applyStimulus(1, 0, 8'h00, 8'h00, 1, 1);
    checkOutput("T1 ADD_R zero", ADD_R_out, 0);
    checkOutput("T1 BUSY zero", BUSY, 0);
    idleCycles(2);

    $display("[TB] T2 basic scan");
    doneSeen = 0;
    applyStimulus(0, 1, 8'h20, 8'd3, 1, 0);
    checkOutput("T2 first beat", ADD_R_out, 8'h20);
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 0);
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 1);
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 0);
    checkOutput("T2 result sel", Select_line, 1);
    checkOutput("T2 result temp", TEMP_ADD_R_out, 8'h21);
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 0);
    checkOutput("T2 DONE at +5", DONE, 1);
    idleCycles(2);
    checkOutput("T2 done count", doneSeen, 1);

    $display("[TB] T3 backpressure");
    applyStimulus(0, 1, 8'h20, 8'd3, 1, 0);
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 8'h00, 8'h00, 0, 1);
      checkOutput("T3 held addr", ADD_R_out, 8'h21);
      checkOutput("T3 held valid", ADDR_VALID, 1);
    end
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 1);
    idleCycles(4);

    $display("[TB] T4 wrap-around");
    applyStimulus(0, 1, 8'hFE, 8'd3, 1, 0);
    idleCycles(3);
    checkOutput("T4 result temp", TEMP_ADD_R_out, 8'hFE);
    idleCycles(3);
    checkOutput("T4 final addr", ADD_R_out, 8'h01);

    $display("[TB] T5 COUNT zero");
    applyStimulus(0, 1, 8'h40, 8'd0, 1, 0);
    checkOutput("T5 DONE next", DONE, 1);
    checkOutput("T5 no VALID", ADDR_VALID, 0);
    idleCycles(2);

    $display("[TB] T6 START ignored while busy");
    doneSeen = 0;
    applyStimulus(0, 1, 8'h30, 8'd4, 1, 0);
    applyStimulus(0, 1, 8'h80, 8'd2, 1, 0);
    applyStimulus(0, 1, 8'h80, 8'd2, 1, 0);
    checkOutput("T6 scan unchanged", ADD_R_out, 8'h32);
    idleCycles(6);
    checkOutput("T6 done count", doneSeen, 1);

    $display("[TB] random traffic");
    for (int i = 0; i < 4000; i++) begin
      logic [7:0] cnt;
      cnt = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
      applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0),
                    8'($urandom), cnt, ($urandom_range(0, 9) < 7),
                    ($urandom_range(0, 2) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
